exc_ctrl: RTL and testbench
===========================

Name: exc_ctrl

Overview:
- Exception/interrupt controller in the MEM stage of the MIPS pipeline; it sequences the CP0 register block.
- Each cycle it inspects the MEM-stage instruction's exception flags and the CP0 Status/Cause state, then selects one exception by fixed priority.
- It waits for any outstanding data-bus transaction to drain, drives the CP0 exception inputs for exactly one cycle, then flushes the pipeline and redirects the PC to the exception vector or to EPC (for ERET).

Parameters:
- EXC_VECTOR, 32'hBFC00380, exception entry PC.
- ERET_CODE, 32'h0000000E, excepttype value for ERET.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- mem_valid_i  in  1  MEM stage holds a real instruction (not a bubble).
- mem_pc_i  in  32  PC of the MEM-stage instruction.
- mem_in_delayslot_i  in  1  MEM instruction is in a branch delay slot.
- mem_exc_flags_i  in  8  exception flags:
  - [0] fetch AdEL
  - [1] reserved instruction
  - [2] overflow
  - [3] syscall
  - [4] break
  - [5] eret
  - [6] load AdEL
  - [7] store AdES
- mem_data_addr_i  in  32  effective data address of the MEM instruction.
- cp0_status_i  in  32  current CP0 Status.
- cp0_cause_i  in  32  current CP0 Cause.
- cp0_epc_i  in  32  current CP0 EPC.
- dbus_busy_i  in  1  a data-bus transaction is outstanding.
- excepttype_o  out  32  exception code to CP0; nonzero only in COMMIT.
- current_inst_addr_o  out  32  faulting PC to CP0.
- is_in_delayslot_o  out  1  delay-slot flag to CP0.
- bad_addr_o  out  32  BadVAddr value to CP0.
- stall_o  out  1  freezes IF through MEM.
- flush_o  out  1  one-cycle pipeline flush.
- new_pc_o  out  32  redirect target; valid while flush_o=1.

Behaviour:
- Reset: state=IDLE; all outputs and internal latches = 0.
- Interrupt pending (int_pend): Status[0]=1 AND Status[1]=0 AND |(Cause[15:8] & Status[15:8]).
- Detection runs in IDLE only, and only when mem_valid_i=1. Priority, highest first:
  - int_pend → 0x01
  - fetch AdEL → 0x04, bad = mem_pc_i
  - RI → 0x0A
  - Ov → 0x0C
  - syscall → 0x08
  - break → 0x09
  - eret → ERET_CODE
  - load AdEL → 0x04, bad = mem_data_addr_i
  - store AdES → 0x05, bad = mem_data_addr_i
- Codes without a listed bad address latch bad = 0.
- No event selected: stay in IDLE with stall_o=0, flush_o=0.
- FSM states: IDLE, DRAIN, COMMIT, FLUSH.
- IDLE:
  - On a selected event, latch code, mem_pc_i, mem_in_delayslot_i and bad address.
  - Next state is DRAIN if dbus_busy_i=1, else COMMIT.
  - stall_o is asserted combinationally in the detection cycle.
- DRAIN:
  - stall_o=1.
  - Stay while dbus_busy_i=1; go to COMMIT on the first cycle with dbus_busy_i=0.
  - No cycle limit.
- COMMIT:
  - stall_o=1 and excepttype_o = latched code for exactly this cycle.
  - current_inst_addr_o, is_in_delayslot_o and bad_addr_o driven from the latches.
  - Always advances to FLUSH.
- FLUSH:
  - flush_o=1 and stall_o=0.
  - new_pc_o = cp0_epc_i if the latched code is ERET_CODE, else EXC_VECTOR.
  - Always advances to IDLE.
- Outside COMMIT: excepttype_o=0. The other CP0 outputs hold their latched values, so CP0 never sees a spurious exception.
- Outside FLUSH: flush_o=0 and new_pc_o=0.
- Latency without drain: detect at cycle N, COMMIT at N+1, FLUSH at N+2. Each DRAIN cycle adds one cycle.
- While in DRAIN, COMMIT or FLUSH, new flags and interrupts are ignored. The instruction arriving in MEM after FLUSH is a bubble.
- Interrupts are ignored while Status.EXL=1 or Status.IE=0. Synchronous exceptions are still taken when EXL=1.
- Multiple flags in one cycle: only the highest-priority one is reported; the others are dropped.
- rst asserted in any state: on the next edge state=IDLE, outputs=0, latches cleared; no partial commit is emitted.

Test Plan:
- Syscall, delay slot, no busy: mem_pc_i=0x80001000, mem_in_delayslot_i=1, flags=0x08 → next cycle excepttype_o=0x8, current_inst_addr_o=0x80001000, is_in_delayslot_o=1; following cycle flush_o=1, new_pc_o=0xBFC00380.
- Load AdEL with drain: flags=0x40, mem_data_addr_i=0x80000003, dbus_busy_i=1 for 3 cycles → stall_o=1 for 3 DRAIN cycles, then excepttype_o=0x4, bad_addr_o=0x80000003, then flush.
- Priority: Status=0x0000FF01, Cause[10]=1, flags=0x06 → excepttype_o=0x1 (interrupt wins). Repeat with Status[1]=1 → excepttype_o=0xA.
- ERET: flags=0x20, cp0_epc_i=0xBFC00700 → excepttype_o=0xE for one cycle, then flush_o=1, new_pc_o=0xBFC00700.
- Masking/bubbles: Cause[15]=1, Status=0x00000001 (IM=0) → no exception, stall_o=0. mem_valid_i=0 with flags=0xFF → no action.
- Reset mid-DRAIN: assert rst while in DRAIN → next cycle state IDLE, stall_o=0, excepttype_o=0; no COMMIT afterwards.

Source files
------------

// File: rtl/exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : exc_ctrl
// Brief    : MEM-stage exception/interrupt sequencer driving the CP0 block.
// Revision : 1.0 - initial release
// ============================================================================
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter logic [31:0] ERET_CODE  = 32'h0000000E
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delayslot_i,
    input  logic [7:0]  mem_exc_flags_i,
    input  logic [31:0] mem_data_addr_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        dbus_busy_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic [31:0] bad_addr_o,
    output logic        stall_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRAIN  = 2'd1,
        S_COMMIT = 2'd2,
        S_FLUSH  = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_code;
    logic [31:0] r_pc;
    logic [31:0] r_bad;
    logic        r_ds;

    logic        w_int_pend;
    logic        w_hit;
    logic [31:0] w_code;
    logic [31:0] w_bad;
    logic        w_unused;

    // IE=1, EXL=0 and at least one unmasked pending line
    assign w_int_pend = cp0_status_i[0] & ~cp0_status_i[1]
                      & (|(cp0_cause_i[15:8] & cp0_status_i[15:8]));

    assign w_unused = ^{cp0_status_i[31:16], cp0_status_i[7:2],
                        cp0_cause_i[31:16], cp0_cause_i[7:0]};

    always_comb begin
        w_hit  = mem_valid_i;
        w_code = 32'd0;
        w_bad  = 32'd0;
        if (w_int_pend) begin
            w_code = 32'h01;
        end else if (mem_exc_flags_i[0]) begin
            w_code = 32'h04;
            w_bad  = mem_pc_i;
        end else if (mem_exc_flags_i[1]) begin
            w_code = 32'h0A;
        end else if (mem_exc_flags_i[2]) begin
            w_code = 32'h0C;
        end else if (mem_exc_flags_i[3]) begin
            w_code = 32'h08;
        end else if (mem_exc_flags_i[4]) begin
            w_code = 32'h09;
        end else if (mem_exc_flags_i[5]) begin
            w_code = ERET_CODE;
        end else if (mem_exc_flags_i[6]) begin
            w_code = 32'h04;
            w_bad  = mem_data_addr_i;
        end else if (mem_exc_flags_i[7]) begin
            w_code = 32'h05;
            w_bad  = mem_data_addr_i;
        end else begin
            w_hit  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_code  <= 32'd0;
            r_pc    <= 32'd0;
            r_bad   <= 32'd0;
            r_ds    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
                        r_code  <= w_code;
                        r_pc    <= mem_pc_i;
                        r_ds    <= mem_in_delayslot_i;
                        r_bad   <= w_bad;
                        r_state <= dbus_busy_i ? S_DRAIN : S_COMMIT;
                    end
                end
                S_DRAIN: begin
                    if (!dbus_busy_i) begin
                        r_state <= S_COMMIT;
                    end
                end
                S_COMMIT: r_state <= S_FLUSH;
                S_FLUSH:  r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // Code is presented only in COMMIT so CP0 never latches a stale exception
    assign excepttype_o        = (r_state == S_COMMIT) ? r_code : 32'd0;
    assign current_inst_addr_o = r_pc;
    assign is_in_delayslot_o   = r_ds;
    assign bad_addr_o          = r_bad;
    assign stall_o             = ((r_state == S_IDLE) && w_hit)
                               || (r_state == S_DRAIN)
                               || (r_state == S_COMMIT);
    assign flush_o             = (r_state == S_FLUSH);
    assign new_pc_o            = (r_state != S_FLUSH) ? 32'd0 :
                                 (r_code == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;

endmodule
`default_nettype wire

// File: tb/tb_exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_exc_ctrl
// Brief    : Self-checking bench for exc_ctrl: directed cases plus random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid_i;
    logic [31:0] mem_pc_i;
    logic        mem_in_delayslot_i;
    logic [7:0]  mem_exc_flags_i;
    logic [31:0] mem_data_addr_i;
    logic [31:0] cp0_status_i;
    logic [31:0] cp0_cause_i;
    logic [31:0] cp0_epc_i;
    logic        dbus_busy_i;
    logic [31:0] excepttype_o;
    logic [31:0] current_inst_addr_o;
    logic        is_in_delayslot_o;
    logic [31:0] bad_addr_o;
    logic        stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    exc_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .mem_valid_i         (mem_valid_i),
        .mem_pc_i            (mem_pc_i),
        .mem_in_delayslot_i  (mem_in_delayslot_i),
        .mem_exc_flags_i     (mem_exc_flags_i),
        .mem_data_addr_i     (mem_data_addr_i),
        .cp0_status_i        (cp0_status_i),
        .cp0_cause_i         (cp0_cause_i),
        .cp0_epc_i           (cp0_epc_i),
        .dbus_busy_i         (dbus_busy_i),
        .excepttype_o        (excepttype_o),
        .current_inst_addr_o (current_inst_addr_o),
        .is_in_delayslot_o   (is_in_delayslot_o),
        .bad_addr_o          (bad_addr_o),
        .stall_o             (stall_o),
        .flush_o             (flush_o),
        .new_pc_o            (new_pc_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one exception "in flight" described by its timeline
    // (detect cycle, commit cycle once the bus is seen idle, flush = commit+1).
    int          t        = 0;
    bit          m_active = 1'b0;
    int          m_commit = -1;
    logic [31:0] m_code   = 0;
    logic [31:0] m_pc     = 0;
    logic [31:0] m_bad    = 0;
    logic        m_ds     = 0;

    function automatic void pick(output bit hit, output logic [31:0] code, output logic [31:0] bad);
        bit          conds [9];
        logic [31:0] codes [9];
        int          bsel  [9];
        bit          ip;
        ip = cp0_status_i[0] && !cp0_status_i[1] && ((cp0_cause_i[15:8] & cp0_status_i[15:8]) != 0);
        conds = '{ip, mem_exc_flags_i[0], mem_exc_flags_i[1], mem_exc_flags_i[2], mem_exc_flags_i[3],
                   mem_exc_flags_i[4], mem_exc_flags_i[5], mem_exc_flags_i[6], mem_exc_flags_i[7]};
        codes = '{32'h01, 32'h04, 32'h0A, 32'h0C, 32'h08, 32'h09, 32'h0E, 32'h04, 32'h05};
        bsel  = '{0, 1, 0, 0, 0, 0, 0, 2, 2};
        hit = 0; code = 0; bad = 0;
        if (mem_valid_i) begin
            for (int k = 0; k < 9; k++) begin
                if (conds[k] && !hit) begin
                    hit  = 1;
                    code = codes[k];
                    bad  = (bsel[k] == 1) ? mem_pc_i : (bsel[k] == 2) ? mem_data_addr_i : 32'd0;
                end
            end
        end
    endfunction

    always @(negedge clk) begin
        bit          hit;
        logic [31:0] code, bad;
        logic [31:0] e_exc, e_npc;
        logic        e_stall, e_flush;
        if (chk_en) begin
            pick(hit, code, bad);
            e_exc = 0; e_npc = 0; e_stall = 0; e_flush = 0;
            if (!m_active) begin
                e_stall = hit;
            end else if (m_commit < 0 || t < m_commit) begin
                e_stall = 1;
            end else if (t == m_commit) begin
                e_stall = 1;
                e_exc   = m_code;
            end else begin
                e_flush = 1;
                e_npc   = (m_code == 32'h0E) ? cp0_epc_i : 32'hBFC00380;
            end
            check("excepttype", excepttype_o, e_exc);
            check("inst_addr", current_inst_addr_o, m_pc);
            check("delayslot", {31'd0, is_in_delayslot_o}, {31'd0, m_ds});
            check("bad_addr", bad_addr_o, m_bad);
            check("stall", {31'd0, stall_o}, {31'd0, e_stall});
            check("flush", {31'd0, flush_o}, {31'd0, e_flush});
            check("new_pc", new_pc_o, e_npc);
            // advance the model across the coming clock edge
            if (rst) begin
                m_active = 0; m_commit = -1; m_code = 0; m_pc = 0; m_bad = 0; m_ds = 0;
            end else if (!m_active) begin
                if (hit) begin
                    m_active = 1;
                    m_code   = code;
                    m_pc     = mem_pc_i;
                    m_ds     = mem_in_delayslot_i;
                    m_bad    = bad;
                    m_commit = dbus_busy_i ? -1 : t + 1;
                end
            end else if (m_commit < 0) begin
                if (!dbus_busy_i) m_commit = t + 1;
            end else if (t == m_commit + 1) begin
                m_active = 0;
                m_commit = -1;
            end
            t++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        rst = 0; mem_valid_i = 0; mem_pc_i = 0; mem_in_delayslot_i = 0; mem_exc_flags_i = 0;
        mem_data_addr_i = 0; cp0_status_i = 0; cp0_cause_i = 0; cp0_epc_i = 0; dbus_busy_i = 0;
    endtask

    initial begin
        quiet();
        rst = 1;
        @(posedge clk);
        #1 chk_en = 1;
        step();
        rst = 0;
        @(negedge clk);
        check("reset_stall", {31'd0, stall_o}, 32'd0);
        check("reset_exc", excepttype_o, 32'd0);

        // syscall in delay slot, bus idle
        step(); mem_valid_i = 1; mem_pc_i = 32'h80001000; mem_in_delayslot_i = 1; mem_exc_flags_i = 8'h08;
        @(negedge clk); check("sys_detect_stall", {31'd0, stall_o}, 32'd1);
        step(); quiet();
        @(negedge clk);
        check("sys_code", excepttype_o, 32'h8);
        check("sys_pc", current_inst_addr_o, 32'h80001000);
        check("sys_ds", {31'd0, is_in_delayslot_o}, 32'd1);
        step(); @(negedge clk);
        check("sys_flush", {31'd0, flush_o}, 32'd1);
        check("sys_newpc", new_pc_o, 32'hBFC00380);
        step(); @(negedge clk);
        check("sys_after", {31'd0, flush_o}, 32'd0);

        // load AdEL with the data bus busy
        step(); mem_valid_i = 1; mem_exc_flags_i = 8'h40; mem_data_addr_i = 32'h80000003; dbus_busy_i = 1;
        @(negedge clk);
        step(); mem_valid_i = 0; mem_exc_flags_i = 0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) dbus_busy_i = 0;
            @(negedge clk);
            check("ld_drain_stall", {31'd0, stall_o}, 32'd1);
            check("ld_drain_exc", excepttype_o, 32'd0);
            step();
        end
        @(negedge clk);
        check("ld_code", excepttype_o, 32'h4);
        check("ld_bad", bad_addr_o, 32'h80000003);
        step(); @(negedge clk);
        check("ld_flush", {31'd0, flush_o}, 32'd1);

        // interrupt beats RI/Ov, then EXL=1 lets RI through
        for (int r = 0; r < 2; r++) begin
            step(); quiet();
            mem_valid_i = 1; mem_exc_flags_i = 8'h06; cp0_cause_i = 32'h400;
            cp0_status_i = (r == 0) ? 32'h0000FF01 : 32'h0000FF03;
            step(); quiet(); @(negedge clk);
            check("prio_code", excepttype_o, (r == 0) ? 32'h1 : 32'hA);
            step();
        end

        // ERET redirects to EPC
        step(); mem_valid_i = 1; mem_exc_flags_i = 8'h20; cp0_epc_i = 32'hBFC00700;
        step(); mem_valid_i = 0; mem_exc_flags_i = 0; @(negedge clk);
        check("eret_code", excepttype_o, 32'hE);
        step(); @(negedge clk);
        check("eret_newpc", new_pc_o, 32'hBFC00700);
        step(); quiet();

        // masked interrupt and a bubble carrying flags
        mem_valid_i = 1; cp0_cause_i = 32'h8000; cp0_status_i = 32'h1;
        @(negedge clk); check("masked_stall", {31'd0, stall_o}, 32'd0);
        step(); quiet(); mem_exc_flags_i = 8'hFF;
        @(negedge clk); check("bubble_stall", {31'd0, stall_o}, 32'd0);
        step(); @(negedge clk); check("bubble_exc", excepttype_o, 32'd0);

        // reset while draining
        step(); quiet(); mem_valid_i = 1; mem_exc_flags_i = 8'h08; dbus_busy_i = 1; mem_pc_i = 32'h1234;
        step(); mem_valid_i = 0; mem_exc_flags_i = 0; rst = 1;
        @(negedge clk); check("rstd_stall_pre", {31'd0, stall_o}, 32'd1);
        step(); rst = 0; dbus_busy_i = 0;
        @(negedge clk);
        check("rstd_stall", {31'd0, stall_o}, 32'd0);
        check("rstd_exc", excepttype_o, 32'd0);
        check("rstd_pc", current_inst_addr_o, 32'd0);
        step(); @(negedge clk); check("rstd_nocommit", excepttype_o, 32'd0);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            step();
            rst                = ($urandom_range(0, 99) == 0);
            mem_valid_i        = ($urandom_range(0, 3) != 0);
            mem_pc_i           = $urandom;
            mem_in_delayslot_i = $urandom_range(0, 1);
            mem_data_addr_i    = $urandom;
            case ($urandom_range(0, 5))
                0:       mem_exc_flags_i = 8'($urandom);
                1:       mem_exc_flags_i = 8'(1 << $urandom_range(0, 7));
                default: mem_exc_flags_i = 0;
            endcase
            case ($urandom_range(0, 3))
                0:       cp0_status_i = 32'h0000FF01;
                1:       cp0_status_i = 32'h0000FF03;
                2:       cp0_status_i = 32'h00000001;
                default: cp0_status_i = $urandom;
            endcase
            cp0_cause_i = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h0000FF00) : 32'd0;
            cp0_epc_i   = $urandom;
            dbus_busy_i = ($urandom_range(0, 2) == 0);
        end
        step();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
